// File: rtl/sh1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sh1 (package)
//  Description : Shared types and constants for the SH-1 multiply/MAC
//                sequencer: operation codes, sequencer states, latencies and
//                a magnitude helper. SH1_MUL_FAST_EN selects the single-pass
//                long-multiply latency.
//  Revision    : 1.0  initial release
// ============================================================================
package sh1;

  // Multiply-class operation codes delivered by decode/execute
  typedef enum logic [2:0] {
    MUL_L    = 3'd0,
    MULS_W   = 3'd1,
    MULU_W   = 3'd2,
    DMULS_L  = 3'd3,
    DMULU_L  = 3'd4,
    CLRMAC   = 3'd5,
    LDS_MACH = 3'd6,
    LDS_MACL = 3'd7
  } mul_op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W    = 3'd1,
    P0   = 3'd2,
    P1   = 3'd3,
    P2   = 3'd4,
    P3   = 3'd5,
    FIX  = 3'd6
  } mul_state_e;

  // Clock edges from the accept edge (inclusive) to the result being visible
  localparam int MUL_LAT_W = 2;
`ifdef SH1_MUL_FAST_EN
  localparam int MUL_LAT_L = 3;
`else
  localparam int MUL_LAT_L = 6;
`endif

  // Magnitude of a 32-bit two's complement value; 0x80000000 maps to itself,
  // which is the correct magnitude when read back as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sh1_mul16.sv
`default_nettype none
// ============================================================================
//  Module      : sh1_mul16
//  Description : Combinational 17x17 signed multiplier. The 16-bit operands
//                are sign-extended when sign_mode is set and zero-extended
//                otherwise, so one array serves signed and unsigned halves.
//  Revision    : 1.0  initial release
// ============================================================================
module sh1_mul16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sign_mode,
  output logic [33:0] prod
);

  logic signed [16:0] a_x;
  logic signed [16:0] b_x;
  logic signed [33:0] p;

  assign a_x  = {sign_mode & a[15], a};
  assign b_x  = {sign_mode & b[15], b};
  assign p    = a_x * b_x;
  assign prod = p;

endmodule
`default_nettype wire

// File: rtl/sh1_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sh1_mul_ctrl
//  Description : SH-1 multiply sequencer and MACH/MACL register pair. Word
//                multiplies take one pass of the shared 16x16 multiplier;
//                long multiplies take four partial-product passes plus a
//                sign-fix cycle. CLRMAC / LDS-to-MAC complete at accept.
//                Build option SH1_MUL_FAST_EN: long multiplies use a single
//                32x32 unsigned product instead of the four-pass sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module sh1_mul_ctrl
  import sh1::*;
#(
  parameter logic [63:0] MAC_RST_VAL = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  mul_op_e     op_i,
  input  logic [31:0] rm_i,
  input  logic [31:0] rn_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] mach_o,
  output logic [31:0] macl_o
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_W    = W;
  localparam logic [2:0] ST_P0   = P0;
  localparam logic [2:0] ST_P1   = P1;
  localparam logic [2:0] ST_P2   = P2;
  localparam logic [2:0] ST_P3   = P3;
  localparam logic [2:0] ST_FIX  = FIX;

  logic [2:0]  state;
  mul_op_e     cur_op;
  logic [31:0] opn;
  logic [31:0] opm;
  logic        neg;
  logic [63:0] acc;
  logic [31:0] mach;
  logic [31:0] macl;

  logic        accept;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_signed;
  logic [33:0] prod;
  logic [63:0] pp_ext;
  logic [63:0] fix_val;
  logic        unused_prod_msb;

  assign op_ready_o = (state == ST_IDLE);
  assign busy_o     = (state != ST_IDLE);
  assign accept     = op_valid_i & op_ready_o & ~flush_i;
  assign mach_o     = mach;
  assign macl_o     = macl;

  // Partial products are unsigned and never exceed 32 bits
  assign pp_ext          = {32'd0, prod[31:0]};
  assign unused_prod_msb = ^prod[33:32];
  assign fix_val         = neg ? (64'd0 - acc) : acc;

  // Route the operand halves for the current pass into the shared multiplier
  always_comb begin
    mul_a      = opn[15:0];
    mul_b      = opm[15:0];
    mul_signed = 1'b0;
    case (state)
      ST_W:    mul_signed = (cur_op == MULS_W);
      ST_P1:   mul_b = opm[31:16];
      ST_P2:   mul_a = opn[31:16];
      ST_P3: begin
        mul_a = opn[31:16];
        mul_b = opm[31:16];
      end
      default: ;
    endcase
  end

  sh1_mul16 u_mul16 (
    .a         (mul_a),
    .b         (mul_b),
    .sign_mode (mul_signed),
    .prod      (prod)
  );

  // Sequencer, operand latches, accumulator and MAC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cur_op <= MUL_L;
      opn    <= 32'd0;
      opm    <= 32'd0;
      neg    <= 1'b0;
      acc    <= 64'd0;
      mach   <= MAC_RST_VAL[63:32];
      macl   <= MAC_RST_VAL[31:0];
    end else if (flush_i && (state != ST_IDLE)) begin
      // Squash: drop the operation, no MAC write even from FIX
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur_op <= op_i;
            opn    <= rn_i;
            opm    <= rm_i;
            neg    <= 1'b0;
            case (op_i)
              CLRMAC: begin
                mach <= 32'd0;
                macl <= 32'd0;
              end
              LDS_MACH: mach  <= rm_i;
              LDS_MACL: macl  <= rm_i;
              MULS_W, MULU_W: state <= ST_W;
              MUL_L, DMULU_L: state <= ST_P0;
              DMULS_L: begin
                opn   <= abs32(rn_i);
                opm   <= abs32(rm_i);
                neg   <= rn_i[31] ^ rm_i[31];
                state <= ST_P0;
              end
              default: ;
            endcase
          end
        end
        ST_W: begin
          macl  <= prod[31:0];
          state <= ST_IDLE;
        end
`ifdef SH1_MUL_FAST_EN
        ST_P0: begin
          acc   <= {32'd0, opn} * {32'd0, opm};
          state <= ST_FIX;
        end
`else
        ST_P0: begin
          acc   <= pp_ext;
          state <= ST_P1;
        end
`endif
        ST_P1: begin
          acc   <= acc + (pp_ext << 16);
          state <= ST_P2;
        end
        ST_P2: begin
          acc   <= acc + (pp_ext << 16);
          state <= ST_P3;
        end
        ST_P3: begin
          acc   <= acc + (pp_ext << 32);
          state <= ST_FIX;
        end
        ST_FIX: begin
          if (cur_op != MUL_L) mach <= fix_val[63:32];
          macl  <= fix_val[31:0];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sh1_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sh1_mul_ctrl
//  Description : Directed self-checking bench for sh1_mul_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sh1_mul_ctrl;
  import sh1::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  mul_op_e     op_code;
  logic [31:0] rm;
  logic [31:0] rn;
  logic        flush;
  logic        busy;
  logic [31:0] mach;
  logic [31:0] macl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sh1_mul_ctrl #(.MAC_RST_VAL(64'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid_i (op_valid),
    .op_ready_o (op_ready),
    .op_i       (op_code),
    .rm_i       (rm),
    .rn_i       (rn),
    .flush_i    (flush),
    .busy_o     (busy),
    .mach_o     (mach),
    .macl_o     (macl)
  );

  // Present one operation for a single cycle; returns 1ns after its accept edge
  task automatic issue(input mul_op_e op, input logic [31:0] n, input logic [31:0] m);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = op;
    rn       = n;
    rm       = m;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; flush = 1'b0;
    op_code = MUL_L; rn = 32'd0; rm = 32'd0;
    edges(2);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", op_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({mach, macl} !== 64'h0) begin errors++; $display("FAIL reset_mac: got %h expected 0", {mach, macl}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dmuls_basic();
    int cnt = 0;
    issue(DMULS_L, 32'hFFFFFFFE, 32'h00000003);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    checks++; if (cnt !== MUL_LAT_L - 1) begin errors++; $display("FAIL dmuls_busy_cycles: got %0d expected %0d", cnt, MUL_LAT_L - 1); end
    checks++; if (mach !== 32'hFFFFFFFF) begin errors++; $display("FAIL dmuls_mach: got %h expected FFFFFFFF", mach); end
    checks++; if (macl !== 32'hFFFFFFFA) begin errors++; $display("FAIL dmuls_macl: got %h expected FFFFFFFA", macl); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL dmuls_ready_after: got %b expected 1", op_ready); end
  endtask

  task automatic test_dmulu();
    issue(DMULU_L, 32'hFFFFFFFF, 32'hFFFFFFFF);
    edges(MUL_LAT_L - 2);
    checks++; if (macl !== 32'hFFFFFFFA) begin errors++; $display("FAIL dmulu_early: got %h expected FFFFFFFA", macl); end
    edges(1);
    checks++; if (mach !== 32'hFFFFFFFE) begin errors++; $display("FAIL dmulu_mach: got %h expected FFFFFFFE", mach); end
    checks++; if (macl !== 32'h00000001) begin errors++; $display("FAIL dmulu_macl: got %h expected 00000001", macl); end
  endtask

  task automatic test_word();
    issue(LDS_MACH, 32'h0, 32'h12345678);
    issue(MULS_W, 32'h00008000, 32'h00000002);
    checks++; if (macl !== 32'h00000001) begin errors++; $display("FAIL muls_w_early: got %h expected 00000001", macl); end
    edges(MUL_LAT_W - 1);
    checks++; if (macl !== 32'hFFFF0000) begin errors++; $display("FAIL muls_w_macl: got %h expected FFFF0000", macl); end
    checks++; if (mach !== 32'h12345678) begin errors++; $display("FAIL muls_w_mach: got %h expected 12345678", mach); end
    issue(MULU_W, 32'h00008000, 32'h00000002);
    edges(MUL_LAT_W - 1);
    checks++; if (macl !== 32'h00010000) begin errors++; $display("FAIL mulu_w_macl: got %h expected 00010000", macl); end
    checks++; if (mach !== 32'h12345678) begin errors++; $display("FAIL mulu_w_mach: got %h expected 12345678", mach); end
  endtask

  task automatic test_mul_l_and_min();
    issue(LDS_MACH, 32'h0, 32'hAAAA5555);
    issue(MUL_L, 32'h00010000, 32'h00010000);
    edges(MUL_LAT_L - 1);
    checks++; if (macl !== 32'h00000000) begin errors++; $display("FAIL mul_l_macl: got %h expected 00000000", macl); end
    checks++; if (mach !== 32'hAAAA5555) begin errors++; $display("FAIL mul_l_mach: got %h expected AAAA5555", mach); end
    issue(DMULS_L, 32'h80000000, 32'hFFFFFFFF);
    edges(MUL_LAT_L - 1);
    checks++; if (mach !== 32'h00000000) begin errors++; $display("FAIL dmuls_min_mach: got %h expected 00000000", mach); end
    checks++; if (macl !== 32'h80000000) begin errors++; $display("FAIL dmuls_min_macl: got %h expected 80000000", macl); end
  endtask

  task automatic test_flush();
    issue(LDS_MACH, 32'h0, 32'h11111111);
    issue(LDS_MACL, 32'h0, 32'h22222222);
    // Flush during P2 (or FIX in the fast build, since P2 is never reached)
    issue(DMULU_L, 32'hFFFFFFFF, 32'hFFFFFFFF);
    edges((MUL_LAT_L == 6) ? 2 : 1);
    flush = 1'b1;
    edges(1);
    flush = 1'b0;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", op_ready); end
    checks++; if ({mach, macl} !== 64'h11111111_22222222) begin errors++; $display("FAIL flush_mac: got %h expected 1111111122222222", {mach, macl}); end
    issue(CLRMAC, 32'h0, 32'h0);
    checks++; if ({mach, macl} !== 64'h0) begin errors++; $display("FAIL clrmac_after_flush: got %h expected 0", {mach, macl}); end
    edges(6);
    checks++; if ({mach, macl} !== 64'h0) begin errors++; $display("FAIL flush_no_late_commit: got %h expected 0", {mach, macl}); end
  endtask

  task automatic test_flush_fix();
    issue(LDS_MACL, 32'h0, 32'h33333333);
    issue(DMULU_L, 32'hFFFFFFFF, 32'hFFFFFFFF);
    edges(MUL_LAT_L - 2);
    flush = 1'b1;
    edges(1);
    flush = 1'b0;
    checks++; if ({mach, macl} !== 64'h00000000_33333333) begin errors++; $display("FAIL flush_fix_mac: got %h expected 0000000033333333", {mach, macl}); end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    op_valid = 1'b1; flush = 1'b1; op_code = LDS_MACL; rm = 32'h44444444;
    @(posedge clk);
    #1;
    op_code = MULU_W;
    @(posedge clk);
    #1;
    op_valid = 1'b0; flush = 1'b0;
    checks++; if (macl !== 32'h33333333) begin errors++; $display("FAIL flush_idle_macl: got %h expected 33333333", macl); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_async_reset();
    issue(LDS_MACH, 32'h0, 32'hDEADBEEF);
    issue(DMULU_L, 32'hFFFFFFFF, 32'hFFFFFFFF);
    edges(1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({mach, macl} !== 64'h0) begin errors++; $display("FAIL arst_mac: got %h expected 0", {mach, macl}); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", op_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(MULU_W, 32'd3, 32'd5);
    edges(MUL_LAT_W - 1);
    checks++; if (macl !== 32'd15) begin errors++; $display("FAIL arst_mulu_w: got %h expected 0000000f", macl); end
    edges(6);
    checks++; if (mach !== 32'd0) begin errors++; $display("FAIL arst_no_commit: got %h expected 0", mach); end
  endtask

  initial begin
    test_reset();
    test_dmuls_basic();
    test_dmulu();
    test_word();
    test_mul_l_and_min();
    test_flush();
    test_flush_fix();
    test_flush_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a task stalls
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
